// File: rtl/decode_stage_if.sv
// Bundle of the ID-stage inputs and the ID/EX register outputs.
// The slave side is the decode stage itself; the master side drives
// instructions and writeback traffic and observes the EX-bound outputs.
interface decode_stage_if;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;

  logic        StallD;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  RD1Addr;
  logic [4:0]  RD2Addr;
  logic [4:0]  RDAddr;
  logic [31:0] SignImmE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;

  modport master (
    output InstrD, ValidD, FlushE, RegWriteW, WriteRegW, ResultW,
    input  StallD, RD1, RD2, RD1Addr, RD2Addr, RDAddr, SignImmE,
           ALUControlE, ALUSrcE, RegWriteE, MemtoRegE, MemWriteE
  );

  modport slave (
    input  InstrD, ValidD, FlushE, RegWriteW, WriteRegW, ResultW,
    output StallD, RD1, RD2, RD1Addr, RD2Addr, RDAddr, SignImmE,
           ALUControlE, ALUSrcE, RegWriteE, MemtoRegE, MemWriteE
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage with register file, load-use hazard detection
// and the ID/EX pipeline register feeding the execute stage.
module decode_stage (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sign_imm;

  logic [31:0] regs [32];
  logic [31:0] rd1_val;
  logic [31:0] rd2_val;

  logic        dec_legal;
  logic [2:0]  dec_alu;
  logic        dec_alu_src;
  logic        dec_reg_write;
  logic        dec_mem_to_reg;
  logic        dec_mem_write;
  logic [4:0]  dec_dest;
  logic        uses_rt;
  logic        issue;

  assign op       = bus.InstrD[31:26];
  assign funct    = bus.InstrD[5:0];
  assign rs       = bus.InstrD[25:21];
  assign rt       = bus.InstrD[20:16];
  assign rd       = bus.InstrD[15:11];
  assign sign_imm = {{16{bus.InstrD[15]}}, bus.InstrD[15:0]};

  // Register file write port; r0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.RegWriteW && (bus.WriteRegW != 5'd0)) begin
      regs[bus.WriteRegW] <= bus.ResultW;
    end
  end

  // Read ports with write-through so a same-cycle writeback is seen at once.
  always_comb begin
    rd1_val = regs[rs];
    rd2_val = regs[rt];
    if (rs == 5'd0) rd1_val = '0;
    else if (bus.RegWriteW && (bus.WriteRegW == rs)) rd1_val = bus.ResultW;
    if (rt == 5'd0) rd2_val = '0;
    else if (bus.RegWriteW && (bus.WriteRegW == rt)) rd2_val = bus.ResultW;
  end

  // Main decoder; anything not recognised decodes as a bubble.
  always_comb begin
    dec_legal      = 1'b0;
    dec_alu        = 3'b000;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_dest       = 5'd0;
    case (op)
      6'h00: begin
        dec_reg_write = 1'b1;
        dec_dest      = rd;
        dec_legal     = 1'b1;
        case (funct)
          6'h20:   dec_alu = 3'b010;
          6'h22:   dec_alu = 3'b110;
          6'h24:   dec_alu = 3'b000;
          6'h25:   dec_alu = 3'b001;
          6'h2A:   dec_alu = 3'b111;
          default: begin
            dec_legal     = 1'b0;
            dec_reg_write = 1'b0;
            dec_dest      = 5'd0;
          end
        endcase
      end
      6'h08: begin
        dec_legal     = 1'b1;
        dec_alu       = 3'b010;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_dest      = rt;
      end
      6'h23: begin
        dec_legal      = 1'b1;
        dec_alu        = 3'b010;
        dec_alu_src    = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_dest       = rt;
      end
      6'h2B: begin
        dec_legal     = 1'b1;
        dec_alu       = 3'b010;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  // rt is a source operand only for R-type and stores.
  assign uses_rt = (op == 6'h00) || (op == 6'h2B);

  assign bus.StallD = bus.MemtoRegE && (bus.RDAddr != 5'd0) && bus.ValidD &&
                      ((bus.RDAddr == rs) || ((bus.RDAddr == rt) && uses_rt));

  assign issue = dec_legal && bus.ValidD && !bus.FlushE && !bus.StallD;

  // ID/EX register: load the decoded instruction or inject an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !issue) begin
      bus.RD1         <= '0;
      bus.RD2         <= '0;
      bus.RD1Addr     <= '0;
      bus.RD2Addr     <= '0;
      bus.RDAddr      <= '0;
      bus.SignImmE    <= '0;
      bus.ALUControlE <= '0;
      bus.ALUSrcE     <= 1'b0;
      bus.RegWriteE   <= 1'b0;
      bus.MemtoRegE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
    end else begin
      bus.RD1         <= rd1_val;
      bus.RD2         <= rd2_val;
      bus.RD1Addr     <= rs;
      bus.RD2Addr     <= rt;
      bus.RDAddr      <= dec_dest;
      bus.SignImmE    <= sign_imm;
      bus.ALUControlE <= dec_alu;
      bus.ALUSrcE     <= dec_alu_src;
      bus.RegWriteE   <= dec_reg_write;
      bus.MemtoRegE   <= dec_mem_to_reg;
      bus.MemWriteE   <= dec_mem_write;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: an instruction-level model predicts
// the ID/EX outputs every cycle, and directed steps pin key values by hand.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   pass_count  = 0;
  int   check_count = 0;
  bit   compare_en  = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       legal;
    logic [2:0] alu;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [4:0] dest;
  } dec_t;

  logic [31:0] model_regs [32];
  logic [31:0] exp_rd1, exp_rd2, exp_sign_imm;
  logic [4:0]  exp_rd1_addr, exp_rd2_addr, exp_rd_addr;
  logic [2:0]  exp_alu;
  logic        exp_alu_src, exp_reg_write, exp_mem_to_reg, exp_mem_write;

  // Instruction table of the supported MIPS subset.
  function automatic dec_t decode_model(input logic [31:0] instr);
    dec_t d;
    d = '0;
    if (instr[31:26] == 6'h00) begin
      d.legal     = 1'b1;
      d.reg_write = 1'b1;
      d.dest      = instr[15:11];
      case (instr[5:0])
        6'h20: d.alu = 3'b010;
        6'h22: d.alu = 3'b110;
        6'h24: d.alu = 3'b000;
        6'h25: d.alu = 3'b001;
        6'h2A: d.alu = 3'b111;
        default: d = '0;
      endcase
    end else if (instr[31:26] == 6'h08) begin
      d = '{legal: 1'b1, alu: 3'b010, alu_src: 1'b1, reg_write: 1'b1,
            mem_to_reg: 1'b0, mem_write: 1'b0, dest: instr[20:16]};
    end else if (instr[31:26] == 6'h23) begin
      d = '{legal: 1'b1, alu: 3'b010, alu_src: 1'b1, reg_write: 1'b1,
            mem_to_reg: 1'b1, mem_write: 1'b0, dest: instr[20:16]};
    end else if (instr[31:26] == 6'h2B) begin
      d = '{legal: 1'b1, alu: 3'b010, alu_src: 1'b1, reg_write: 1'b0,
            mem_to_reg: 1'b0, mem_write: 1'b1, dest: 5'd0};
    end
    return d;
  endfunction

  function automatic logic reads_rt(input logic [31:0] instr);
    return (instr[31:26] == 6'h00) || (instr[31:26] == 6'h2B);
  endfunction

  // A load in EX whose target is a source of the instruction now in ID.
  function automatic logic model_stall();
    return exp_mem_to_reg && (exp_rd_addr != 5'd0) && bus.ValidD &&
           ((exp_rd_addr == bus.InstrD[25:21]) ||
            ((exp_rd_addr == bus.InstrD[20:16]) && reads_rt(bus.InstrD)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Reference model: apply the writeback, then read, then fill ID/EX.
  always @(posedge clk or posedge rst) begin : model
    logic [31:0] next_regs [32];
    dec_t        d;
    logic        stall_now;
    logic        take;
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] <= '0;
      exp_rd1 <= '0; exp_rd2 <= '0; exp_sign_imm <= '0;
      exp_rd1_addr <= '0; exp_rd2_addr <= '0; exp_rd_addr <= '0;
      exp_alu <= '0; exp_alu_src <= 1'b0; exp_reg_write <= 1'b0;
      exp_mem_to_reg <= 1'b0; exp_mem_write <= 1'b0;
    end else begin
      stall_now = model_stall();
      d = decode_model(bus.InstrD);
      for (int i = 0; i < 32; i++) next_regs[i] = model_regs[i];
      if (bus.RegWriteW && bus.WriteRegW != 5'd0) next_regs[bus.WriteRegW] = bus.ResultW;
      for (int i = 0; i < 32; i++) model_regs[i] <= next_regs[i];
      take = d.legal && bus.ValidD && !bus.FlushE && !stall_now;
      exp_rd1        <= take ? next_regs[bus.InstrD[25:21]] : 32'd0;
      exp_rd2        <= take ? next_regs[bus.InstrD[20:16]] : 32'd0;
      exp_rd1_addr   <= take ? bus.InstrD[25:21] : 5'd0;
      exp_rd2_addr   <= take ? bus.InstrD[20:16] : 5'd0;
      exp_rd_addr    <= take ? d.dest : 5'd0;
      exp_sign_imm   <= take ? {{16{bus.InstrD[15]}}, bus.InstrD[15:0]} : 32'd0;
      exp_alu        <= take ? d.alu : 3'd0;
      exp_alu_src    <= take && d.alu_src;
      exp_reg_write  <= take && d.reg_write;
      exp_mem_to_reg <= take && d.mem_to_reg;
      exp_mem_write  <= take && d.mem_write;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("StallD", {31'd0, bus.StallD}, {31'd0, model_stall()});
      checkOutput("RD1", bus.RD1, exp_rd1);
      checkOutput("RD2", bus.RD2, exp_rd2);
      checkOutput("RD1Addr", {27'd0, bus.RD1Addr}, {27'd0, exp_rd1_addr});
      checkOutput("RD2Addr", {27'd0, bus.RD2Addr}, {27'd0, exp_rd2_addr});
      checkOutput("RDAddr", {27'd0, bus.RDAddr}, {27'd0, exp_rd_addr});
      checkOutput("SignImmE", bus.SignImmE, exp_sign_imm);
      checkOutput("ALUControlE", {29'd0, bus.ALUControlE}, {29'd0, exp_alu});
      checkOutput("ALUSrcE", {31'd0, bus.ALUSrcE}, {31'd0, exp_alu_src});
      checkOutput("RegWriteE", {31'd0, bus.RegWriteE}, {31'd0, exp_reg_write});
      checkOutput("MemtoRegE", {31'd0, bus.MemtoRegE}, {31'd0, exp_mem_to_reg});
      checkOutput("MemWriteE", {31'd0, bus.MemWriteE}, {31'd0, exp_mem_write});
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic flush, input logic reg_write_w,
                               input logic [4:0] write_reg_w, input logic [31:0] result_w);
    @(posedge clk);
    #1;
    bus.InstrD    = instr;
    bus.ValidD    = valid;
    bus.FlushE    = flush;
    bus.RegWriteW = reg_write_w;
    bus.WriteRegW = write_reg_w;
    bus.ResultW   = result_w;
    #1;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    rst = 1'b1;
    bus.InstrD = '0; bus.ValidD = 1'b0; bus.FlushE = 1'b0;
    bus.RegWriteW = 1'b0; bus.WriteRegW = '0; bus.ResultW = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_en = 1'b1;
    #1;
    checkOutput("reset RDAddr", {27'd0, bus.RDAddr}, 32'd0);
    checkOutput("reset StallD", {31'd0, bus.StallD}, 32'd0);
    checkOutput("reset RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);

    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
    applyStimulus(32'h00221820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);   // add r3,r1,r2
    applyStimulus(32'h00803022, 1'b1, 1'b0, 1'b1, 5'd4, 32'hDEADBEEF); // sub r6,r4,r0
    checkOutput("add RD1", bus.RD1, 32'd5);
    checkOutput("add RD2", bus.RD2, 32'd7);
    checkOutput("add RD1Addr", {27'd0, bus.RD1Addr}, 32'd1);
    checkOutput("add RD2Addr", {27'd0, bus.RD2Addr}, 32'd2);
    checkOutput("add RDAddr", {27'd0, bus.RDAddr}, 32'd3);
    checkOutput("add ALUControlE", {29'd0, bus.ALUControlE}, 32'd2);
    checkOutput("add RegWriteE", {31'd0, bus.RegWriteE}, 32'd1);

    applyStimulus(32'h00043820, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);    // add r7,r0,r4
    checkOutput("bypass RD1", bus.RD1, 32'hDEADBEEF);
    checkOutput("sub ALUControlE", {29'd0, bus.ALUControlE}, 32'd6);

    applyStimulus(32'h2022FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // addi r2,r1,-1
    checkOutput("r0 RD1", bus.RD1, 32'd0);
    checkOutput("r4 RD2", bus.RD2, 32'hDEADBEEF);

    applyStimulus(32'h8C220000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // lw r2,0(r1)
    checkOutput("addi SignImmE", bus.SignImmE, 32'hFFFFFFFF);
    checkOutput("addi ALUSrcE", {31'd0, bus.ALUSrcE}, 32'd1);
    checkOutput("addi RDAddr", {27'd0, bus.RDAddr}, 32'd2);

    applyStimulus(32'h00411820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // add r3,r2,r1
    checkOutput("lw MemtoRegE", {31'd0, bus.MemtoRegE}, 32'd1);
    checkOutput("load-use StallD", {31'd0, bus.StallD}, 32'd1);

    applyStimulus(32'h00411820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // held add
    checkOutput("stall bubble RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);
    checkOutput("stall bubble RDAddr", {27'd0, bus.RDAddr}, 32'd0);
    checkOutput("stall released", {31'd0, bus.StallD}, 32'd0);

    applyStimulus(32'h8C220000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // lw r2,0(r1)
    checkOutput("held add RDAddr", {27'd0, bus.RDAddr}, 32'd3);
    checkOutput("held add RD1Addr", {27'd0, bus.RD1Addr}, 32'd2);

    applyStimulus(32'h20C50001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // addi r5,r6,1
    checkOutput("no stall addi", {31'd0, bus.StallD}, 32'd0);

    applyStimulus(32'hAC220004, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);     // sw r2,4(r1) flushed
    checkOutput("addi2 SignImmE", bus.SignImmE, 32'd1);

    applyStimulus(32'hFC00ABCD, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // unknown op
    checkOutput("flush MemWriteE", {31'd0, bus.MemWriteE}, 32'd0);
    checkOutput("flush RD1Addr", {27'd0, bus.RD1Addr}, 32'd0);

    applyStimulus(32'hAC220004, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55);    // sw r2,4(r1)
    checkOutput("unknown SignImmE", bus.SignImmE, 32'd0);
    checkOutput("unknown RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);

    applyStimulus(32'h8C090000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // lw r9,0(r0)
    checkOutput("sw MemWriteE", {31'd0, bus.MemWriteE}, 32'd1);
    checkOutput("sw RDAddr", {27'd0, bus.RDAddr}, 32'd0);
    checkOutput("sw RD2", bus.RD2, 32'd7);
    checkOutput("sw SignImmE", bus.SignImmE, 32'd4);

    applyStimulus(32'hAC690000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);     // sw r9,0(r3) + flush
    checkOutput("flush+stall StallD", {31'd0, bus.StallD}, 32'd1);

    applyStimulus(32'hAC690000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // held sw
    checkOutput("sw stall bubble MemWriteE", {31'd0, bus.MemWriteE}, 32'd0);
    checkOutput("sw stall released", {31'd0, bus.StallD}, 32'd0);

    applyStimulus(32'h8C250000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // lw r5,0(r1)
    checkOutput("held sw MemWriteE", {31'd0, bus.MemWriteE}, 32'd1);
    checkOutput("held sw RD2Addr", {27'd0, bus.RD2Addr}, 32'd9);

    applyStimulus(32'h00A03020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // add r6,r5,r0
    checkOutput("pre-reset StallD", {31'd0, bus.StallD}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid-stall reset StallD", {31'd0, bus.StallD}, 32'd0);
    checkOutput("mid-stall reset RDAddr", {27'd0, bus.RDAddr}, 32'd0);
    checkOutput("mid-stall reset MemtoRegE", {31'd0, bus.MemtoRegE}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(32'h00A03820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);     // add r7,r5,r0
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("r5 after reset", bus.RD1, 32'd0);
    checkOutput("post-reset RDAddr", {27'd0, bus.RDAddr}, 32'd7);

    repeat (2) @(posedge clk);
    #1;
    compare_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage and ID/EX pipeline register of the five-stage pipeline; sits directly upstream of the execute stage and drives its operand, address and control inputs. Decodes a 32-bit MIPS-subset instruction, reads two operands from a 32x32 register file written back from the WB stage, and sign-extends the immediate. Detects load-use hazards, stalls the front end, and injects a bubble into EX.

## Interface
Parameters: none (32-bit datapath, 32 registers, fixed).

- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction in ID
- ValidD  in  1  InstrD holds a real instruction; 0 = bubble
- FlushE  in  1  force bubble into ID/EX next edge (highest priority after rst)
- RegWriteW  in  1  writeback enable
- WriteRegW  in  5  writeback register address
- ResultW  in  32  writeback data
- StallD  out  1  combinational; hold IF/ID and PC this cycle
- RD1, RD2  out  32  registered operands (rs, rt)
- RD1Addr, RD2Addr  out  5  registered rs, rt
- RDAddr  out  5  registered destination address
- SignImmE  out  32  registered sign-extended imm[15:0]
- ALUControlE  out  3  registered ALU operation
- ALUSrcE  out  1  registered; 1 = SignImmE as operand B
- RegWriteE, MemtoRegE, MemWriteE  out  1  registered controls

## Operation
- Decode (op = Instr[31:26], funct = Instr[5:0]):
  - op 0x00, funct 0x20/0x22/0x24/0x25/0x2A: add/sub/and/or/slt; ALUControl 010/110/000/001/111; ALUSrc 0; RegWrite 1; RDAddr = rd.
  - op 0x08 addi: ALUControl 010, ALUSrc 1, RegWrite 1, RDAddr = rt.
  - op 0x23 lw: ALUControl 010, ALUSrc 1, RegWrite 1, MemtoReg 1, RDAddr = rt.
  - op 0x2B sw: ALUControl 010, ALUSrc 1, MemWrite 1, RegWrite 0, RDAddr = 0.
  - any other op/funct: bubble (all controls 0, RDAddr 0).
- Bubble = all registered outputs zero (ALUControl 000, RegWrite/MemWrite/MemtoReg 0, addresses 0, data 0).
- Register file: 32x32; r0 reads 0 always, writes to r0 ignored. Write on rising edge when RegWriteW. Read is combinational with write-through bypass: if RegWriteW and WriteRegW == read address != 0, read returns ResultW.
- Load-use hazard: StallD = MemtoRegE & (RDAddr != 0) & ValidD & ((RDAddr == rs) | (RDAddr == rt && instruction uses rt as source: R-type or sw)).
- ID/EX register next-state priority: rst -> zero; FlushE -> bubble; StallD -> bubble; ValidD = 0 -> bubble; else decoded instruction.
- While StallD is 1 the upstream holds InstrD; this block keeps no copy of it.
- Sign extension: SignImm = {{16{imm[15]}}, imm[15:0]} for all op codes (outputs ignored downstream where unused).

## Timing
- Reset (async assert, released synchronously by pipeline): all ID/EX outputs 0, all 32 registers 0; StallD 0 while reset since MemtoRegE = 0.
- Latency: InstrD at edge N appears on E outputs after edge N+1 (one cycle).
- Write-then-read in same cycle returns new value (bypass); register updated at the same edge.
- Load-use stall lasts exactly one cycle: the bubble clears MemtoRegE, so StallD drops next cycle; the held instruction then issues normally with forwarding from MEM handled downstream.
- FlushE concurrent with StallD: bubble inserted, StallD still asserted (upstream holds).
- Reset mid-stall: outputs and StallD go to 0 immediately (async); register file contents lost.

## Test plan
- Reset: assert rst mid-run -> all E outputs 0, StallD 0; read r5 after release -> 0.
- Writeback + R-type: write r1=5, r2=7 then InstrD add r3,r1,r2 (0x00221820) -> next cycle RD1=5, RD2=7, RD1Addr=1, RD2Addr=2, RDAddr=3, ALUControlE=010, RegWriteE=1.
- Bypass: RegWriteW=1, WriteRegW=4, ResultW=0xDEADBEEF same cycle as sub r6,r4,r0 -> RD1=0xDEADBEEF; writeback to r0 -> r0 still reads 0.
- addi r2,r1,-1 (0x2022FFFF) -> SignImmE=0xFFFFFFFF, ALUSrcE=1, RDAddr=2.
- Load-use: lw r2,0(r1) followed by add r3,r2,r1 -> StallD=1 for one cycle, E outputs bubble, then add issues; lw r2 followed by addi r5,r6,1 -> no stall.
- FlushE=1 with valid sw -> next cycle MemWriteE=0, all outputs 0; unknown op 0x3F -> bubble.
